// File: rtl/divider_64_pkg.sv
// Shared constants and FSM encoding for the 64-bit signed sequential divider.
package div_pkg;
    localparam int WIDTH = 64;
    localparam int CNT_W = $clog2(WIDTH);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIX  = 2'd2;
endpackage

// File: rtl/divider_64_if.sv
// Operand/result handshake bundle between the datapath (master) and the divider (slave).
interface divider_64_if
    import div_pkg::*;
();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_by_zero;

    modport master (output start, a, b, input busy, done, q, r, div_by_zero);
    modport slave  (input start, a, b, output busy, done, q, r, div_by_zero);
endinterface

// File: rtl/divider_64_abs_neg.sv
// Combinational conditional two's-complement negate, used for |x| and for sign fixup.
module div_abs_neg #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);
    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;
endmodule

// File: rtl/divider_64.sv
// Radix-2 restoring signed divider: one quotient bit per clock on operand magnitudes,
// signs applied in a final fixup cycle; b==0 skips straight to that cycle.
module divider_64
    import div_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    divider_64_if.slave   bus
);
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH:0]   r_dsr;
    logic             r_sign_a;
    logic             r_sign_q;
    logic             r_div0;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH:0]   w_abs_b;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;

    // Divisor kept one bit wider so |MIN| = 2^63 is represented exactly.
    div_abs_neg #(.W(WIDTH))   u_abs_a (.i_val(bus.a), .i_neg(bus.a[WIDTH-1]), .o_val(w_abs_a));
    div_abs_neg #(.W(WIDTH+1)) u_abs_b (.i_val({bus.b[WIDTH-1], bus.b}), .i_neg(bus.b[WIDTH-1]), .o_val(w_abs_b));
    div_abs_neg #(.W(WIDTH))   u_fix_q (.i_val(r_dvd), .i_neg(r_sign_q), .o_val(w_q));
    div_abs_neg #(.W(WIDTH))   u_fix_r (.i_val(r_rem[WIDTH-1:0]), .i_neg(r_sign_a), .o_val(w_r));

    // The top bit of the difference acts as the borrow: clear means rem >= divisor.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dsr};
    assign w_ge    = ~w_diff[WIDTH+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_sign_a <= 1'b0;
            r_sign_q <= 1'b0;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_dvd    <= w_abs_a;
                        r_dsr    <= w_abs_b;
                        r_sign_a <= bus.a[WIDTH-1];
                        r_sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_rem    <= '0;
                        r_cnt    <= CNT_W'(WIDTH - 1);
                        r_busy   <= 1'b1;
                        r_div0   <= (bus.b == '0);
                        r_state  <= (bus.b == '0) ? ST_FIX : ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_rem <= w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    r_q     <= r_div0 ? '0 : w_q;
                    r_r     <= r_div0 ? '0 : w_r;
                    r_dbz   <= r_div0;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.q           = r_q;
    assign bus.r           = r_r;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_divider_64.sv
// Directed-vector bench for divider_64: results, latency, busy length, reset abort.
module tb_divider_64;
    import div_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    divider_64_if bus ();

    divider_64 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        logic        dbz;
        int          lat;
        int          inject;
    } vec_t;

    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

    vec_t vecs [11] = '{
        '{64'd10,       64'd3,   64'd3,                  64'd1,   1'b0, 65, -1},
        '{64'd100,      64'd10,  64'd10,                 64'd0,   1'b0, 65, -1},
        '{64'd1,        64'd2,   64'd0,                  64'd1,   1'b0, 65, -1},
        '{-64'd1,       64'd2,   64'd0,                  -64'd1,  1'b0, 65, -1},
        '{-64'd7,       64'd2,   -64'd3,                 -64'd1,  1'b0, 65, -1},
        '{64'd7,        -64'd2,  -64'd3,                 64'd1,   1'b0, 65, -1},
        '{MIN,          64'd2,   64'hC000_0000_0000_0000, 64'd0,  1'b0, 65, -1},
        '{MIN,          -64'd1,  MIN,                    64'd0,   1'b0, 65, -1},
        '{64'd5,        64'd0,   64'd0,                  64'd0,   1'b1, 1,  -1},
        '{64'd10,       64'd3,   64'd3,                  64'd1,   1'b0, 65, -1},
        '{64'd100,      64'd7,   64'd14,                 64'd2,   1'b0, 65, 10}
    };

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; start is seen at the next edge, then done is awaited.
    task automatic applyStimulus(input string tag, input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] expQ, input logic [63:0] expR,
                                 input logic expDbz, input int expLat, input int injectAt);
        int cnt;
        int busyCnt;
        cnt     = 0;
        busyCnt = 0;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 64'h1234_5678_9ABC_DEF0;
        bus.b     = 64'd3;
        while (!bus.done && cnt < 200) begin
            if (bus.busy) busyCnt++;
            bus.start = (cnt == injectAt);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            cnt++;
        end
        checkOutput({tag, " latency"}, 64'(cnt), 64'(expLat));
        checkOutput({tag, " busy cycles"}, 64'(busyCnt), 64'(expLat));
        checkOutput({tag, " q"}, bus.q, expQ);
        checkOutput({tag, " r"}, bus.r, expR);
        checkOutput({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(expDbz));
        checkOutput({tag, " busy with done"}, 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, " done one cycle"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int doneSeen;
        logic [63:0] ra;
        logic [63:0] rb;
        total = 0;
        bad   = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        checkOutput("reset q", bus.q, 64'd0);
        checkOutput("reset r", bus.r, 64'd0);
        checkOutput("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);

        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                          vecs[i].dbz, vecs[i].lat, vecs[i].inject);
        end

        // Abort a long division partway through the iterations.
        bus.start = 1'b1;
        bus.a     = 64'd1000;
        bus.b     = 64'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort busy", 64'(bus.busy), 64'd0);
        checkOutput("abort q", bus.q, 64'd0);
        checkOutput("abort r", bus.r, 64'd0);
        checkOutput("abort div_by_zero", 64'(bus.div_by_zero), 64'd0);
        doneSeen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.done) doneSeen++;
        end
        checkOutput("abort no done", 64'(doneSeen), 64'd0);
        applyStimulus("after abort", 64'd10, 64'd3, 64'd3, 64'd1, 1'b0, 65, -1);

        for (int k = 0; k < 8; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (k % 2 == 1) rb = 64'($signed(rb) >>> 40);
            if (rb == '0 || rb == '1) rb = 64'd3;
            applyStimulus($sformatf("rand%0d", k), ra, rb,
                          64'($signed(ra) / $signed(rb)), 64'($signed(ra) % $signed(rb)),
                          1'b0, 65, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
